// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: aligns and extends load data, registers the four writeback candidates.
// Optional retired-instruction counter enabled by defining MEM_WB_INSTRET_EN.
module mem_wb_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [XLEN-1:0]      alu_result,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic [XLEN-1:0]      pc_plus4,
    input  logic [XLEN-1:0]      imm,
    input  logic [1:0]           wb_sel,
    input  logic [2:0]           funct3,
    input  logic                 is_load,
    input  logic [RF_ADDR_W-1:0] rd,
    input  logic                 reg_write,
    output logic [XLEN-1:0]      wb_alu,
    output logic [XLEN-1:0]      wb_mem,
    output logic [XLEN-1:0]      wb_pc4,
    output logic [XLEN-1:0]      wb_imm,
    output logic [1:0]           wb_sel_q,
    output logic [RF_ADDR_W-1:0] wb_rd,
    output logic                 wb_reg_write,
    output logic                 wb_valid
`ifdef MEM_WB_INSTRET_EN
    ,
    output logic [63:0]          instret
`endif
);

    logic [1:0]           off;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [XLEN-1:0]      mem_d;
    logic                 rw_d;

    logic [XLEN-1:0]      alu_q;
    logic [XLEN-1:0]      mem_q;
    logic [XLEN-1:0]      pc4_q;
    logic [XLEN-1:0]      imm_q;
    logic [1:0]           sel_q;
    logic [RF_ADDR_W-1:0] rd_q;
    logic                 rw_q;
    logic                 valid_q;

    assign off = alu_result[1:0];

    // Little-endian lane selection; funct3[2] distinguishes zero- from sign-extension.
    always_comb begin
        byte_sel = mem_rdata[{off, 3'b000} +: 8];
        half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        mem_d    = mem_rdata;
        if (is_load) begin
            case (funct3)
                3'b000:  mem_d = {{(XLEN-8){byte_sel[7]}}, byte_sel};
                3'b100:  mem_d = {{(XLEN-8){1'b0}}, byte_sel};
                3'b001:  mem_d = {{(XLEN-16){half_sel[15]}}, half_sel};
                3'b101:  mem_d = {{(XLEN-16){1'b0}}, half_sel};
                default: mem_d = mem_rdata;
            endcase
        end
    end

    assign rw_d = reg_write & in_valid & (rd != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q   <= '0;
            mem_q   <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            sel_q   <= '0;
            rd_q    <= '0;
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only the qualifiers are killed.
            rw_q    <= 1'b0;
            valid_q <= 1'b0;
        end else if (!stall) begin
            alu_q   <= alu_result;
            mem_q   <= mem_d;
            pc4_q   <= pc_plus4;
            imm_q   <= imm;
            sel_q   <= wb_sel;
            rd_q    <= rd;
            rw_q    <= rw_d;
            valid_q <= in_valid;
        end
    end

    assign wb_alu       = alu_q;
    assign wb_mem       = mem_q;
    assign wb_pc4       = pc4_q;
    assign wb_imm       = imm_q;
    assign wb_sel_q     = sel_q;
    assign wb_rd        = rd_q;
    assign wb_reg_write = rw_q;
    assign wb_valid     = valid_q;

`ifdef MEM_WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (!flush && !stall && in_valid) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline register for the RV32I five-stage core. It captures the memory-stage results and aligns and sign/zero-extends load data. It registers the four writeback candidates (ALU result, load data, PC+4, immediate) plus the 2-bit select, which feed the downstream writeback 4:1 mux directly. It also qualifies the register-file write enable, supports stall and flush, and optionally counts retired instructions.

Parameters:
XLEN, 32, datapath width; only 32 is supported.
RF_ADDR_W, 5, register-file index width.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hold all stage registers.
flush  in  1  insert bubble.
in_valid  in  1  MEM-stage instruction valid.
alu_result  in  32  ALU result; also the load byte address.
mem_rdata  in  32  raw word from data memory.
pc_plus4  in  32  PC+4 of the instruction.
imm  in  32  U-type immediate (LUI).
wb_sel  in  2  writeback source: 00 ALU, 01 MEM, 10 PC+4, 11 IMM.
funct3  in  3  load width/sign field.
is_load  in  1  instruction is a load.
rd  in  5  destination register.
reg_write  in  1  register-file write request.
wb_alu  out  32  registered ALU result (mux input 00).
wb_mem  out  32  registered aligned load data (mux input 01).
wb_pc4  out  32  registered PC+4 (mux input 10).
wb_imm  out  32  registered immediate (mux input 11).
wb_sel_q  out  2  registered select for the writeback mux.
wb_rd  out  5  registered destination register.
wb_reg_write  out  1  qualified register-file write enable.
wb_valid  out  1  WB-stage instruction valid.
instret  out  64  retired-instruction count (only with the optional feature).

Behaviour:
- Single clock domain, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Register update priority on each rising edge: rst > flush > stall > normal load.
- rst: all outputs go to 0. wb_sel_q=00, wb_valid=0, wb_reg_write=0, instret=0.
- flush (with or without stall): wb_valid=0 and wb_reg_write=0. Data registers may take any value; the bench checks only wb_valid and wb_reg_write.
- stall with no flush: every register holds its value. instret does not increment.
- Normal load: all inputs are captured. Latency is 1 cycle from the MEM-stage inputs to the outputs.
- wb_valid <= in_valid.
- wb_reg_write <= reg_write & in_valid & (rd != 0). This means x0 is never written.
- Load alignment uses off = alu_result[1:0] and is applied before the register:
  - funct3=000 (LB): byte at off, sign-extended.
  - funct3=100 (LBU): byte at off, zero-extended.
  - funct3=001 (LH): halfword selected by off[1], sign-extended. off[0] is ignored.
  - funct3=101 (LHU): halfword selected by off[1], zero-extended.
  - funct3=010 (LW): raw word. off is ignored.
  - Reserved funct3 values (011, 110, 111): raw word.
  - Byte 0 is mem_rdata[7:0] (little-endian).
- When is_load=0, wb_mem <= mem_rdata unmodified.
- wb_sel values are passed through unchanged. Code 11 is legal (LUI). No decoding of wb_sel is done in this block.
- Reset applied mid-stall clears the stage. Stall is ignored during the rst cycle.

Optional Feature:
Macro: MEM_WB_INSTRET_EN.
- Defined: the instret port exists. instret is a 64-bit counter that increments by 1 on each clock edge where stall=0, flush=0, rst=0 and in_valid=1. It wraps from 2^64-1 to 0. It is cleared by rst.
- Undefined: the instret port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset: drive rst=1 for 2 cycles with inputs non-zero -> all outputs 0, wb_valid=0, wb_sel_q=00.
- Load extension: mem_rdata=32'h8077_F0A5, is_load=1, in_valid=1, reg_write=1, rd=5. Expected wb_mem one cycle later:
  - LB, off=0 -> FFFFFFA5.
  - LBU, off=1 -> 000000F0.
  - LH, off=2 -> FFFF8077.
  - LHU, off=0 -> 0000F0A5.
  - LW, off=3 -> 8077F0A5.
  - funct3=011 -> 8077F0A5.
- Passthrough: alu_result=0x10, pc_plus4=0x104, imm=0xABCDE000, wb_sel=10, rd=1 -> next cycle wb_alu=0x10, wb_pc4=0x104, wb_imm=0xABCDE000, wb_sel_q=10, wb_rd=1, wb_reg_write=1.
- x0 suppression: rd=0, reg_write=1, in_valid=1 -> wb_reg_write=0, wb_valid=1.
- Stall and flush:
  - Load instruction A, then hold stall=1 for 3 cycles while changing inputs -> outputs stay at A's values.
  - Then assert stall=1 and flush=1 together -> wb_valid=0, wb_reg_write=0.
- Counter (MEM_WB_INSTRET_EN defined): 10 valid cycles, 2 of them stalled and 1 flushed -> instret=7. With the macro undefined, the design builds with no instret port.
